// File: rtl/bp_l15_req_arbiter.sv
// Two-requester front end for the OpenPiton L1.5 transducer channel.
// Requester 0 is the D-cache miss transducer, requester 1 the I-cache one.
// Round-robin grant, locked from grant until the L1.5 accepts it. One request
// may be outstanding. Returns go back to the owner. Interrupt returns always
// go to int_owner_p. A watchdog flags a return that never arrives.
module bp_l15_req_arbiter #(
  parameter logic [3:0] int_ret_p   = 4'b0111,
  parameter int         int_owner_p = 0,
  parameter int         timeout_p   = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,

  input  logic [1:0]        req_v_i,
  input  logic [1:0][4:0]   req_rqtype_i,
  input  logic [1:0][2:0]   req_size_i,
  input  logic [1:0][39:0]  req_addr_i,
  input  logic [1:0][63:0]  req_data_i,
  input  logic [1:0][1:0]   req_rplway_i,
  output logic [1:0]        req_ack_o,

  output logic [1:0]        ret_v_o,
  output logic [3:0]        ret_type_o,
  output logic [127:0]      ret_data_o,
  input  logic [1:0]        ret_yumi_i,

  output logic              transducer_l15_val,
  output logic [4:0]        transducer_l15_rqtype,
  output logic [2:0]        transducer_l15_size,
  output logic [39:0]       transducer_l15_address,
  output logic [63:0]       transducer_l15_data,
  output logic [1:0]        transducer_l15_l1rplway,
  input  logic              l15_transducer_ack,

  input  logic              l15_transducer_val,
  input  logic [3:0]        l15_transducer_returntype,
  input  logic [63:0]       l15_transducer_data_0,
  input  logic [63:0]       l15_transducer_data_1,
  output logic              transducer_l15_req_ack,

  output logic              owner_o,
  output logic              busy_o,
  output logic              error_o
);

  typedef enum logic [1:0] {e_idle, e_send, e_wait} state_e;

  localparam int             WD_W    = $clog2(timeout_p + 1);
  localparam logic [WD_W-1:0] WD_TO   = WD_W'(timeout_p);
  localparam logic [WD_W-1:0] WD_TO_M1 = WD_W'(timeout_p - 1);
  localparam logic           INT_OWN = 1'(int_owner_p);

  state_e          state_r, state_n;
  logic            owner_r;
  logic            ptr_r;
  logic [WD_W-1:0] wd_r;
  logic            error_r;

  logic            winner;
  logic            is_int_ret;
  logic            own_ret;
  logic            accept;
  logic            own_consume;

  // Decode return and handshake conditions shared by state and output logic
  always_comb begin
    winner      = req_v_i[ptr_r] ? ptr_r : ~ptr_r;
    is_int_ret  = l15_transducer_val && (l15_transducer_returntype == int_ret_p);
    own_ret     = l15_transducer_val && !is_int_ret && (state_r == e_wait);
    accept      = (state_r == e_send) && l15_transducer_ack;
    own_consume = own_ret && ret_yumi_i[owner_r];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next-state logic: grant is held in e_send until the L1.5 accepts it
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (|req_v_i)   state_n = e_send;
      e_send:  if (accept)     state_n = e_wait;
      e_wait:  if (own_consume) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Owner latch, round-robin pointer, watchdog and sticky error flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_r <= 1'b0;
      ptr_r   <= 1'b0;
      wd_r    <= '0;
      error_r <= 1'b0;
    end else begin
      if ((state_r == e_idle) && (|req_v_i)) owner_r <= winner;
      if (accept) ptr_r <= ~owner_r;
      if (own_consume) begin
        wd_r <= '0;
      end else if ((state_r == e_wait) && (wd_r != WD_TO)) begin
        wd_r <= wd_r + 1'b1;
      end
      if ((state_r == e_wait) && (wd_r == WD_TO_M1)) error_r <= 1'b1;
    end
  end

  // Output logic: request mux toward the L1.5, return routing toward requesters
  always_comb begin
    transducer_l15_val      = (state_r == e_send);
    transducer_l15_rqtype   = '0;
    transducer_l15_size     = '0;
    transducer_l15_address  = '0;
    transducer_l15_data     = '0;
    transducer_l15_l1rplway = '0;
    if (transducer_l15_val) begin
      transducer_l15_rqtype   = req_rqtype_i[owner_r];
      transducer_l15_size     = req_size_i[owner_r];
      transducer_l15_address  = req_addr_i[owner_r];
      transducer_l15_data     = req_data_i[owner_r];
      transducer_l15_l1rplway = req_rplway_i[owner_r];
    end

    req_ack_o = '0;
    if (accept) req_ack_o[owner_r] = 1'b1;

    ret_v_o                = '0;
    transducer_l15_req_ack = 1'b0;
    if (is_int_ret) begin
      ret_v_o[INT_OWN]       = 1'b1;
      transducer_l15_req_ack = ret_yumi_i[INT_OWN];
    end else if (own_ret) begin
      ret_v_o[owner_r]       = 1'b1;
      transducer_l15_req_ack = ret_yumi_i[owner_r];
    end

    ret_type_o = l15_transducer_returntype;
    ret_data_o = {l15_transducer_data_1, l15_transducer_data_0};
    owner_o    = owner_r;
    busy_o     = (state_r != e_idle);
    error_o    = error_r;
  end

endmodule

// File: doc/bp_l15_req_arbiter.md
Name: bp_l15_req_arbiter

Overview:
- Shares the single OpenPiton L1.5 transducer request/return channel between two BlackParrot miss engines: requester 0 is the D-cache miss transducer and requester 1 is the I-cache miss transducer.
- Round-robin arbitration on requests, with the winner locked until the L1.5 acks the request.
- At most one request outstanding at a time; each return is routed back to the requester that owns the outstanding request.
- Sits between the per-cache transducers and the L1.5 pins. Includes a watchdog that flags a hung return.

Parameters:
- int_ret_p, 4'b0111: L1.5 returntype code for an interrupt return.
- int_owner_p, 0: requester that receives interrupt returns.
- timeout_p, 1024: wait-for-return cycles before error_o is set.

Ports:
- clk_i in 1: clock
- reset_i in 1: synchronous active-high reset
- req_v_i in 2: per-requester request valid; the request must be held with stable fields until req_ack_o
- req_rqtype_i in 2x5: request type, per requester
- req_size_i in 2x3: request size, per requester
- req_addr_i in 2x40: request address, per requester
- req_data_i in 2x64: store data, per requester
- req_rplway_i in 2x2: L1 replacement way, per requester
- req_ack_o out 2: one-cycle pulse when the L1.5 accepts that requester's request
- ret_v_o out 2: per-requester return valid
- ret_type_o out 4: returntype, passed through
- ret_data_o out 128: {data_1, data_0}, passed through
- ret_yumi_i in 2: requester consumes the return
- transducer_l15_val out 1: request valid to the L1.5
- transducer_l15_rqtype out 5: request type to the L1.5
- transducer_l15_size out 3: request size to the L1.5
- transducer_l15_address out 40: request address to the L1.5
- transducer_l15_data out 64: store data to the L1.5
- transducer_l15_l1rplway out 2: replacement way to the L1.5
- l15_transducer_ack in 1: L1.5 request accept
- l15_transducer_val in 1: L1.5 return valid
- l15_transducer_returntype in 4: return type
- l15_transducer_data_0 in 64: return data, low
- l15_transducer_data_1 in 64: return data, high
- transducer_l15_req_ack out 1: return consumed
- owner_o out 1: current or last granted requester
- busy_o out 1: state is not e_idle
- error_o out 1: sticky watchdog flag

Behaviour:
- Reset values: state e_idle, priority pointer 0, owner 0, watchdog 0, error_o 0. All outputs are 0 except data/address, which are 0 as a consequence of val=0.
- Reset mid-operation drops any outstanding request. The L1.5 side is re-synchronised by the system reset.

States:
- e_idle: if any req_v_i is set, latch the winner into owner_r and go to e_send.
  - Winner is the pointer-preferred requester if it is valid, otherwise the other one.
  - Single-cycle decision; no outputs are driven toward the L1.5.
- e_send: transducer_l15_val=1; all fields are muxed from owner_r's live inputs.
  - On l15_transducer_ack: pulse req_ack_o[owner_r], set pointer = ~owner_r, go to e_wait.
  - The grant never switches while in e_send, even if the other requester is valid.
- e_wait: watchdog increments each cycle.
  - A non-interrupt return with l15_transducer_val asserts ret_v_o[owner_r].
  - transducer_l15_req_ack = ret_yumi_i[owner_r]. On that yumi, go to e_idle and clear the watchdog.
  - When the watchdog reaches timeout_p, error_o sets and stays set until reset. The state is unchanged.

Interrupt returns (returntype == int_ret_p):
- Routed to int_owner_p in any state.
- transducer_l15_req_ack = ret_yumi_i[int_owner_p].
- The state is unchanged, and the routing takes precedence over a concurrent owner return (the two cannot coexist on the single return bus).

Non-interrupt return outside e_wait:
- Not acked and not routed; the L1.5 holds it.

Request latency:
- Request valid to transducer_l15_val is 1 cycle.
- A back-to-back grant needs at least 1 cycle of e_idle after return consumption.

Pass-through and width rules:
- ret_type_o and ret_data_o are always the raw L1.5 return type and data; only ret_v_o is gated.
- Pointer update happens only on request accept, so a requester that keeps its valid asserted cannot starve the other.

Test Plan:
- Single D-cache load: req_v=01, addr 0x80_0000_0040, rqtype LOAD_RQ.
  - transducer_l15_val rises 1 cycle later with that address.
  - On ack, req_ack_o=01 for one cycle.
  - Return LOAD_RET with data 0xAA..: ret_v_o=01; after yumi, req_ack pulses and busy_o falls.
- Contention: req_v=11 held from reset.
  - Grants alternate 0,1,0,1 over four request/return rounds.
  - The address on the L1.5 interface matches each winner's address.
- Interrupt during wait: owner=1 in e_wait, an INT_RET (4'b0111) arrives.
  - ret_v_o=01, consumed by requester 0; state stays e_wait.
  - A following LOAD_RET goes to requester 1.
- Stalled ack: hold l15_transducer_ack=0 for 20 cycles while req_v toggles to 11.
  - transducer_l15_val and the address stay those of the original owner; no req_ack_o pulse.
- Watchdog: timeout_p=16, no return after ack.
  - error_o=1 at the 16th wait cycle and remains 1 after a later return.
  - A subsequent reset clears it.
- Reset mid-wait: assert reset_i in e_wait.
  - Next cycle: busy_o=0, owner_o=0, error_o=0, all ret_v_o=0.
